// File: rtl/syncram_sp_responder.sv
// Single-port RAM responder with per-word even parity, a zeroizing sweep,
// runtime capacity range check, parity-error logging and fault injection.
module syncram_sp_responder #(
   parameter int WID    = 32,
   parameter int DEPTH  = 1024,
   parameter int WCOUNT = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              softreset,
   input  logic              start_clear,
   input  logic [15:0]       capacity,
   input  logic              wen,
   input  logic              cen,
   input  logic [WCOUNT-1:0] addr,
   input  logic [WID-1:0]    wdata,
   input  logic              inject_err,
   output logic [WID-1:0]    rdata,
   output logic              busy,
   output logic              bad_access,
   output logic              parity_err,
   output logic [15:0]       err_count,
   output logic [WCOUNT-1:0] err_addr
);

   typedef enum logic {
      S_CLEAR,
      S_READY
   } state_t;

   localparam logic [16:0]       DEPTH17 = 17'(DEPTH);
   localparam logic [WCOUNT-1:0] LAST    = WCOUNT'(DEPTH - 1);

   state_t              state_q;
   logic [WCOUNT-1:0]   clr_ptr_q;
   logic [WID-1:0]      rdata_q;
   logic                bad_q;
   logic                perr_q;
   logic [15:0]         cnt_q;
   logic [WCOUNT-1:0]   eaddr_q;
   logic [WID:0]        mem_q [DEPTH];

   logic [16:0]         cap17;
   logic [16:0]         ecap;
   logic [16:0]         addr17;
   logic                in_range;
   logic                acc_req;
   logic                acc_ok;
   logic                rd_ok;
   logic                wr_ok;
   logic [WID:0]        rd_word;
   logic                chk;

   always_comb begin
      cap17    = {1'b0, capacity};
      ecap     = (capacity == 16'd0 || cap17 > DEPTH17) ? DEPTH17 : cap17;
      addr17   = {{(17 - WCOUNT){1'b0}}, addr};
      in_range = addr17 < ecap;
      // softreset swallows any access presented with it
      acc_req  = ~cen & ~softreset;
      acc_ok   = acc_req & (state_q == S_READY) & in_range;
      rd_ok    = acc_ok & wen;
      wr_ok    = acc_ok & ~wen;
      rd_word  = mem_q[addr];
      chk      = ^rd_word;
   end

   always_ff @(posedge clk) begin
      if (state_q == S_CLEAR) begin
         mem_q[clr_ptr_q] <= '0;
      end else if (wr_ok) begin
         mem_q[addr] <= {(^wdata) ^ inject_err, wdata};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_CLEAR;
         clr_ptr_q <= '0;
         rdata_q   <= '0;
         bad_q     <= 1'b0;
         perr_q    <= 1'b0;
         cnt_q     <= '0;
         eaddr_q   <= '0;
      end else begin
         bad_q <= acc_req & ~acc_ok;
         if (softreset) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
            perr_q    <= 1'b0;
            cnt_q     <= '0;
            eaddr_q   <= '0;
         end else begin
            unique case (state_q)
               S_CLEAR: begin
                  if (clr_ptr_q == LAST) begin
                     state_q   <= S_READY;
                     clr_ptr_q <= '0;
                  end else begin
                     clr_ptr_q <= clr_ptr_q + 1'b1;
                  end
               end
               S_READY: begin
                  if (start_clear) state_q <= S_CLEAR;
               end
               default: state_q <= S_CLEAR;
            endcase
            if (rd_ok) begin
               rdata_q <= rd_word[WID-1:0];
               if (chk) begin
                  perr_q <= 1'b1;
                  if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                  if (!perr_q) eaddr_q <= addr;
               end
            end
         end
      end
   end

   assign rdata      = rdata_q;
   assign busy       = (state_q == S_CLEAR);
   assign bad_access = bad_q;
   assign parity_err = perr_q;
   assign err_count  = cnt_q;
   assign err_addr   = eaddr_q;

endmodule

// File: tb/tb_syncram_sp_responder.sv
// Directed bench for syncram_sp_responder (DEPTH 16): table of single-cycle
// accesses plus hand-written sweep, softreset and start_clear sequences.
module tb_syncram_sp_responder;

   logic        clk;
   logic        rst_n;
   logic        softreset;
   logic        start_clear;
   logic [15:0] capacity;
   logic        wen;
   logic        cen;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic        inject_err;
   logic [31:0] rdata;
   logic        busy;
   logic        bad_access;
   logic        parity_err;
   logic [15:0] err_count;
   logic [3:0]  err_addr;

   int checks = 0;
   int errors = 0;

   syncram_sp_responder #(
      .WID  (32),
      .DEPTH(16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .softreset  (softreset),
      .start_clear(start_clear),
      .capacity   (capacity),
      .wen        (wen),
      .cen        (cen),
      .addr       (addr),
      .wdata      (wdata),
      .inject_err (inject_err),
      .rdata      (rdata),
      .busy       (busy),
      .bad_access (bad_access),
      .parity_err (parity_err),
      .err_count  (err_count),
      .err_addr   (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        cen;
      logic        wen;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic        inj;
      logic [15:0] cap;
      logic [31:0] e_rd;
      logic        e_bad;
      logic        e_perr;
      logic [15:0] e_cnt;
      logic [3:0]  e_ea;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic c, input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic inj, input logic [15:0] cp);
      cen        = c;
      wen        = w;
      addr       = a;
      wdata      = d;
      inject_err = inj;
      capacity   = cp;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(input string nm);
      int n;
      n = 0;
      while (busy && n < 100) begin
         n++;
         step();
      end
      chk(nm, 64'(n), 64'd16);
   endtask

   task automatic read_all_zero(input string nm);
      for (int i = 0; i < 16; i++) begin
         drv(1'b0, 1'b1, 4'(i), 32'h0, 1'b0, 16'd16);
         step();
         chk(nm, {rdata, bad_access, parity_err}, {32'h0, 1'b0, 1'b0});
      end
      drv(1'b1, 1'b1, 4'd0, 32'h0, 1'b0, 16'd16);
   endtask

   initial begin
      tbl.push_back('{0, 0, 4'd5,  32'hDEADBEEF, 0, 16'd16, 32'h0,        0, 0, 16'd0, 4'd0});
      tbl.push_back('{0, 1, 4'd5,  32'h0,        0, 16'd16, 32'hDEADBEEF, 0, 0, 16'd0, 4'd0});
      tbl.push_back('{0, 0, 4'd12, 32'h12345678, 0, 16'd10, 32'hDEADBEEF, 1, 0, 16'd0, 4'd0});
      tbl.push_back('{1, 1, 4'd0,  32'h0,        0, 16'd16, 32'hDEADBEEF, 0, 0, 16'd0, 4'd0});
      tbl.push_back('{0, 1, 4'd12, 32'h0,        0, 16'd16, 32'h0,        0, 0, 16'd0, 4'd0});
      tbl.push_back('{0, 1, 4'd5,  32'h0,        0, 16'd5,  32'h0,        1, 0, 16'd0, 4'd0});
      tbl.push_back('{0, 1, 4'd5,  32'h0,        0, 16'd6,  32'hDEADBEEF, 0, 0, 16'd0, 4'd0});
      tbl.push_back('{0, 1, 4'd12, 32'h0,        0, 16'd0,  32'h0,        0, 0, 16'd0, 4'd0});
      tbl.push_back('{0, 1, 4'd5,  32'h0,        0, 16'd17, 32'hDEADBEEF, 0, 0, 16'd0, 4'd0});
      tbl.push_back('{0, 1, 4'd12, 32'h0,        0, 16'hFFFF, 32'h0,      0, 0, 16'd0, 4'd0});
      tbl.push_back('{0, 0, 4'd3,  32'hA5A50001, 1, 16'd16, 32'h0,        0, 0, 16'd0, 4'd0});
      tbl.push_back('{0, 1, 4'd3,  32'h0,        0, 16'd16, 32'hA5A50001, 0, 1, 16'd1, 4'd3});
      tbl.push_back('{0, 1, 4'd3,  32'h0,        0, 16'd16, 32'hA5A50001, 0, 1, 16'd2, 4'd3});
      tbl.push_back('{0, 0, 4'd7,  32'h000000FF, 1, 16'd16, 32'hA5A50001, 0, 1, 16'd2, 4'd3});
      tbl.push_back('{0, 1, 4'd7,  32'h0,        0, 16'd16, 32'h000000FF, 0, 1, 16'd3, 4'd3});
      tbl.push_back('{0, 1, 4'd5,  32'h0,        0, 16'd16, 32'hDEADBEEF, 0, 1, 16'd3, 4'd3});
      tbl.push_back('{0, 0, 4'd9,  32'h00000001, 0, 16'd16, 32'hDEADBEEF, 0, 1, 16'd3, 4'd3});
      tbl.push_back('{0, 1, 4'd9,  32'h0,        0, 16'd16, 32'h00000001, 0, 1, 16'd3, 4'd3});

      rst_n       = 1'b0;
      softreset   = 1'b0;
      start_clear = 1'b0;
      drv(1'b1, 1'b1, 4'd0, 32'h0, 1'b0, 16'd16);
      step();
      step();
      chk("reset", {rdata, bad_access, parity_err, err_count, err_addr, busy},
          {32'h0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1});
      rst_n = 1'b1;
      count_busy("reset_sweep_len");
      read_all_zero("reset_read0");

      foreach (tbl[i]) begin
         drv(tbl[i].cen, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].inj, tbl[i].cap);
         step();
         chk($sformatf("row%0d", i),
             {rdata, bad_access, parity_err, err_count, err_addr, busy},
             {tbl[i].e_rd, tbl[i].e_bad, tbl[i].e_perr, tbl[i].e_cnt, tbl[i].e_ea, 1'b0});
      end

      // softreset with a read pending: log cleared, read dropped, rdata held
      softreset = 1'b1;
      drv(1'b0, 1'b1, 4'd5, 32'h0, 1'b0, 16'd16);
      step();
      softreset = 1'b0;
      drv(1'b1, 1'b1, 4'd0, 32'h0, 1'b0, 16'd16);
      chk("softreset", {rdata, bad_access, parity_err, err_count, err_addr, busy},
          {32'h1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1});
      begin
         int n;
         n = 0;
         while (busy && n < 100) begin
            n++;
            start_clear = (n == 3);
            drv((n != 5), 1'b1, 4'd5, 32'h0, 1'b0, 16'd16);
            step();
            if (n == 5) chk("clr_read_bad", {rdata, bad_access}, {32'h1, 1'b1});
            if (n == 6) chk("clr_bad_pulse", {31'h0, bad_access}, 64'h0);
         end
         start_clear = 1'b0;
         drv(1'b1, 1'b1, 4'd0, 32'h0, 1'b0, 16'd16);
         chk("soft_sweep_len", 64'(n), 64'd16);
      end

      drv(1'b0, 1'b1, 4'd3, 32'h0, 1'b0, 16'd16);
      step();
      chk("post_soft_rd3", {rdata, parity_err, err_count}, {32'h0, 1'b0, 16'h0});

      drv(1'b0, 1'b0, 4'd5, 32'hCAFEF00D, 1'b0, 16'd16);
      step();
      start_clear = 1'b1;
      drv(1'b0, 1'b1, 4'd5, 32'h0, 1'b0, 16'd16);
      step();
      start_clear = 1'b0;
      drv(1'b1, 1'b1, 4'd0, 32'h0, 1'b0, 16'd16);
      chk("start_clear_rd", {rdata, bad_access, busy}, {32'hCAFEF00D, 1'b0, 1'b1});
      count_busy("start_clear_len");
      read_all_zero("clear_read0");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/syncram_sp_responder.md
# syncram_sp_responder

Memory-side responder for the single-port RAM interface driven by the team's RAM-based FIFOs: active-low `wen`/`cen`, a shared `addr`, `wdata` out and `rdata` back one cycle later. It holds a DEPTH×(WID+1) array with one even-parity bit per word. It adds a zeroization state machine, address range checking against the FIFO's runtime `capacity`, parity-error logging, and parity fault injection for verification. It sits between a FIFO controller and the physical SRAM, or stands in for the SRAM in simulation and FPGA builds.

## Interface
- `WID`, 32, data word width.
- `DEPTH`, 1024, number of words.
- `WCOUNT`, `$clog2(DEPTH)`, address width.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `softreset`  in  1  synchronous; restarts the clear sweep and zeroes the error log.
- `start_clear`  in  1  single-cycle request to zeroize; honoured only in READY.
- `capacity`  in  16  usable depth; 0 or >DEPTH means DEPTH.
- `wen`  in  1  active-low write enable (0 = write, 1 = read).
- `cen`  in  1  active-low chip enable; no access when 1.
- `addr`  in  WCOUNT  word address.
- `wdata`  in  WID  write data.
- `inject_err`  in  1  when high during a write, the stored parity bit is inverted.
- `rdata`  out  WID  read data.
- `busy`  out  1  high while in CLEAR.
- `bad_access`  out  1  one-cycle pulse flagging a rejected access.
- `parity_err`  out  1  sticky flag, set on any parity mismatch.
- `err_count`  out  16  number of parity mismatches, saturating.
- `err_addr`  out  WCOUNT  address of the first mismatch.

## Operation
- **Effective capacity.** `ecap` = `capacity` when 1 ≤ `capacity` ≤ DEPTH, otherwise DEPTH. Compare at 17 bits, with `addr` zero-extended.
- **FSM states:** CLEAR, READY.
- **CLEAR:**
  - Writes `{parity 0, data 0}` to word `clr_ptr` every cycle, `clr_ptr` counting 0 → DEPTH-1.
  - When `clr_ptr` = DEPTH-1, the FSM moves to READY and `clr_ptr` returns to 0.
  - The sweep covers all DEPTH words regardless of `ecap`.
- **READY:**
  - `start_clear` = 1 → CLEAR. An access presented in the same cycle as `start_clear` is still serviced.
  - `start_clear` in CLEAR is ignored.
- **Access valid:** `cen` = 0, state = READY, `addr` < `ecap`.
- **Access rejected:**
  - Any access with `cen` = 0 is rejected if state = CLEAR or `addr` ≥ `ecap`.
  - A rejected access does not change the array, `rdata` or the error log.
  - `bad_access` = 1 on the following cycle.
- **Write** (`wen` = 0): stores `wdata` and parity `^wdata ^ inject_err`.
- **Read** (`wen` = 1):
  - `rdata` is loaded with the stored word.
  - Compute `chk` = `^data ^ stored_parity`. If `chk` = 1:
    - `parity_err` is set.
    - `err_count` increments, holding at 16'hFFFF once reached.
    - `err_addr` is latched only if `parity_err` was 0 before this read.
  - The corrupted data is still returned on `rdata`.
- **softreset:**
  - FSM → CLEAR, `clr_ptr` → 0.
  - `parity_err`, `err_count`, `err_addr` and `bad_access` → 0.
  - `rdata` is held.
  - softreset takes priority over `start_clear` and over any access in the same cycle; that access is not serviced and is not flagged.
- **Reset values** (on `rst_n` low):
  - state CLEAR, `busy` 1, `clr_ptr` 0.
  - `rdata` 0, `bad_access` 0, `parity_err` 0, `err_count` 0, `err_addr` 0.
  - Array contents are undefined until the first sweep completes.

## Timing
- **Read latency:** a read presented at edge N drives `rdata` valid after edge N+1. `rdata` holds until the next valid read.
- **Write:** takes effect at the edge where it is presented. A read of the same address in the next cycle returns the new data; there is no bypass required within the same cycle.
- **Read and write in the same cycle:** impossible on a single port. `wen` selects which one occurs.
- **Sweep duration:**
  - After `rst_n` deasserts, `busy` stays high for exactly DEPTH cycles.
  - After `start_clear` is sampled in READY, `busy` rises on the next cycle and stays high for DEPTH cycles.
- **Parity logging:** `parity_err`, `err_count` and `err_addr` update on the same edge that loads `rdata`.
- **`bad_access`:** asserted for one cycle, on the cycle after the rejected access.
- **Back-to-back reads:** one per cycle, with no bubble required.
- **Reset mid-sweep:** asserting `rst_n` low or `softreset` during CLEAR restarts the sweep from 0.

## Test plan
- **Reset sweep:** DEPTH = 16; release `rst_n` → `busy` = 1 for exactly 16 cycles. Then read addresses 0..15 → `rdata` = 0 each time and `parity_err` = 0.
- **Write/read:** capacity 16; write 32'hDEADBEEF to address 5, then read address 5 on the next cycle → `rdata` = 32'hDEADBEEF one cycle after the read; no `bad_access`.
- **Out-of-range and during-clear access:**
  - capacity = 10; write address 12 → `bad_access` pulses; a later read of address 12 with capacity = 16 returns 0.
  - A read during `busy` → `bad_access` pulses and `rdata` is unchanged.
- **Fault injection:** write address 3 with `inject_err` = 1; read address 3 twice → `parity_err` = 1, `err_count` = 2, `err_addr` = 3, and `rdata` is the data written.
- **Error-log ordering:** after a fault at address 3, inject a fault at address 7 and read it → `err_addr` stays 3 and `err_count` = 3.
- **softreset and start_clear:**
  - Assert `softreset` while a read is requested → log cleared, read not serviced, `busy` = 1 for DEPTH cycles.
  - `start_clear` in READY → all words read back 0 afterwards.
  - `start_clear` during CLEAR → sweep length unchanged.
